// File: rtl/aes_round_ctrl_if.sv
// Block-level bus of the AES round controller: plaintext in, key-store lookup,
// external round-function datapath and ciphertext out.
interface aes_round_ctrl_if;
  logic         inValid;
  logic         inReady;
  logic [127:0] plainIn;
  logic         keyReady;
  logic [3:0]   rkIdx;
  logic [127:0] roundKey;
  logic [127:0] rfIn;
  logic         rfLast;
  logic [127:0] rfOut;
  logic         outValid;
  logic         outReady;
  logic [127:0] cipherOut;
  logic         busy;

  // master: the environment around the controller (source, key store, round fn, sink)
  modport master (
    output inValid, plainIn, keyReady, roundKey, rfOut, outReady,
    input  inReady, rkIdx, rfIn, rfLast, outValid, cipherOut, busy
  );

  modport slave (
    input  inValid, plainIn, keyReady, roundKey, rfOut, outReady,
    output inReady, rkIdx, rfIn, rfLast, outValid, cipherOut, busy
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: whitening on accept, then one external round per cycle
// for NR rounds, then hold the ciphertext until the consumer takes it.
module aes_round_ctrl #(
  parameter int NR = 10  // 10, 12 or 14
) (
  input  logic           clk,
  input  logic           rst,
  aes_round_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [3:0] NR_L  = 4'(NR);

  logic [1:0]   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic         in_idle, in_round, in_done, accept;

  assign in_idle  = (fsm_q == IDLE);
  assign in_round = (fsm_q == ROUND);
  assign in_done  = (fsm_q == DONE);
  assign accept   = in_idle && bus.inValid && bus.keyReady;

  assign bus.inReady   = in_idle && bus.keyReady;
  assign bus.rkIdx     = in_round ? round_q : 4'd0;
  assign bus.rfIn      = state_q;
  assign bus.rfLast    = in_round && (round_q == NR_L);
  assign bus.outValid  = in_done;
  assign bus.cipherOut = state_q;
  assign bus.busy      = in_round || in_done;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          // rkIdx is 0 here, so roundKey is the whitening key
          state_d = bus.plainIn ^ bus.roundKey;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = bus.rfOut ^ bus.roundKey;
        if (round_q == NR_L) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        // the following cycle is IDLE, so a new block can never overlap this edge
        if (bus.outReady) begin
          fsm_d   = IDLE;
          round_d = 4'd0;
        end
      end
      default: begin
        fsm_d   = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: stub, random and FIPS-197 environments around NR=10
// and NR=14 instances, checked against a round-by-round cipher model.
module tb_aes_round_ctrl;

  localparam int NR10 = 10;
  localparam int NR14 = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;       // 0 stub, 1 random rounds/keys, 2 real AES-128
  int   nCmp = 0;
  int   nErr = 0;
  logic [127:0] rkTab [16];
  logic [127:0] aesRk [16];

  aes_round_ctrl_if if10 ();
  aes_round_ctrl_if if14 ();

  aes_round_ctrl #(.NR(NR10)) dut10 (.clk(clk), .rst(rst), .bus(if10.slave));
  aes_round_ctrl #(.NR(NR14)) dut14 (.clk(clk), .rst(rst), .bus(if14.slave));

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0] b [16];
    logic [7:0] o [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = o[4*c]; a1 = o[4*c+1]; a2 = o[4*c+2]; a3 = o[4*c+3];
        o[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        o[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        o[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        o[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
    return res;
  endfunction

  function automatic logic [127:0] rf_rand(input logic [127:0] s, input logic last);
    if (last) return {s[114:0], s[127:115]} ^ 128'hc3a5_5a3c_0f1e_2d4b_8796_a5b4_c3d2_e1f0;
    return {s[120:0], s[127:121]} ^ 128'h1357_9bdf_2468_ace0_fedc_ba98_7654_3210;
  endfunction

  // cipher as a sequence of rounds: whiten with key 0, then NR rounds each
  // followed by its round key, the last one without MixColumns
  function automatic logic [127:0] model(input logic [127:0] p, input int nr);
    logic [127:0] s;
    s = p ^ ((mode == 0) ? 128'd0 : (mode == 1) ? rkTab[0] : aesRk[0]);
    for (int r = 1; r <= nr; r++) begin
      case (mode)
        0:       s = s ^ 128'(r);
        1:       s = rf_rand(s, r == nr) ^ rkTab[r];
        default: s = aes_round(s, r == nr) ^ aesRk[r];
      endcase
    end
    return s;
  endfunction

  always_comb begin
    case (mode)
      0: begin if10.roundKey = {124'b0, if10.rkIdx}; if10.rfOut = if10.rfIn; end
      1: begin if10.roundKey = rkTab[if10.rkIdx]; if10.rfOut = rf_rand(if10.rfIn, if10.rfLast); end
      default: begin if10.roundKey = aesRk[if10.rkIdx]; if10.rfOut = aes_round(if10.rfIn, if10.rfLast); end
    endcase
  end

  always_comb begin
    case (mode)
      0: begin if14.roundKey = {124'b0, if14.rkIdx}; if14.rfOut = if14.rfIn; end
      1: begin if14.roundKey = rkTab[if14.rkIdx]; if14.rfOut = rf_rand(if14.rfIn, if14.rfLast); end
      default: begin if14.roundKey = aesRk[if14.rkIdx]; if14.rfOut = aes_round(if14.rfIn, if14.rfLast); end
    endcase
  end

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) aesRk[r] = '0;
    for (int r = 0; r < 11; r++) aesRk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic offer(input logic [127:0] p, output bit acc);
    if10.plainIn = p;
    if10.inValid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 40 && !acc; n++) begin
      #1;
      if (if10.inReady) acc = 1'b1;
      @(negedge clk);
    end
    if10.inValid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!if10.outValid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    if10.outReady = 1'b1;
    @(negedge clk);
    if10.outReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if10.keyReady = 1'b1;
    repeat (2) @(negedge clk);
    nCmp++; if (if10.outValid !== 1'b0) begin nErr++; $display("FAIL rst_outValid: got %b want 0", if10.outValid); end
    nCmp++; if (if10.busy !== 1'b0) begin nErr++; $display("FAIL rst_busy: got %b want 0", if10.busy); end
    nCmp++; if (if10.rfLast !== 1'b0) begin nErr++; $display("FAIL rst_rfLast: got %b want 0", if10.rfLast); end
    nCmp++; if (if10.cipherOut !== 128'd0) begin nErr++; $display("FAIL rst_cipherOut: got %h want 0", if10.cipherOut); end
    nCmp++; if (if10.rfIn !== 128'd0) begin nErr++; $display("FAIL rst_rfIn: got %h want 0", if10.rfIn); end
    nCmp++; if (if10.rkIdx !== 4'd0) begin nErr++; $display("FAIL rst_rkIdx: got %0d want 0", if10.rkIdx); end
    nCmp++; if (if10.inReady !== 1'b1) begin nErr++; $display("FAIL rst_inReady_k1: got %b want 1", if10.inReady); end
    if10.keyReady = 1'b0;
    #1;
    nCmp++; if (if10.inReady !== 1'b0) begin nErr++; $display("FAIL rst_inReady_k0: got %b want 0", if10.inReady); end
    @(negedge clk);
    rst = 1'b0;
    if10.keyReady = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stub();
    logic [127:0] p = 128'h0123456789abcdef0123456789abcdef;
    bit acc;
    int lat;
    mode = 0;
    offer(p, acc);
    nCmp++; if (acc !== 1'b1) begin nErr++; $display("FAIL stub_accept: got %b want 1", acc); end
    wait_out(lat);
    nCmp++; if (lat !== NR10 + 1) begin nErr++; $display("FAIL stub_latency: got %0d want %0d", lat, NR10 + 1); end
    nCmp++; if (if10.cipherOut !== (p ^ 128'hb)) begin nErr++; $display("FAIL stub_cipher: got %h want %h", if10.cipherOut, p ^ 128'hb); end
    nCmp++; if (if10.busy !== 1'b1) begin nErr++; $display("FAIL stub_busy_done: got %b want 1", if10.busy); end
    release_out();
    nCmp++; if (if10.busy !== 1'b0) begin nErr++; $display("FAIL stub_idle_after: got busy %b want 0", if10.busy); end
  endtask

  task automatic test_fips();
    bit acc;
    int lat;
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    mode = 2;
    @(negedge clk);
    offer(128'h00112233445566778899aabbccddeeff, acc);
    wait_out(lat);
    nCmp++; if (if10.cipherOut !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      nErr++; $display("FAIL fips_cipher: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", if10.cipherOut); end
    nCmp++; if (lat !== NR10 + 1) begin nErr++; $display("FAIL fips_latency: got %0d want %0d", lat, NR10 + 1); end
    release_out();
  endtask

  task automatic test_random();
    logic [127:0] p, exp_c;
    bit acc;
    int lat;
    mode = 1;
    for (int i = 0; i < 16; i++) rkTab[i] = rnd128();
    for (int b = 0; b < 6; b++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      p = rnd128();
      exp_c = model(p, NR10);
      offer(p, acc);
      wait_out(lat);
      nCmp++; if (lat !== NR10 + 1) begin nErr++; $display("FAIL rand_latency[%0d]: got %0d want %0d", b, lat, NR10 + 1); end
      nCmp++; if (if10.cipherOut !== exp_c) begin nErr++; $display("FAIL rand_cipher[%0d]: got %h want %h", b, if10.cipherOut, exp_c); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      nCmp++; if (if10.cipherOut !== exp_c || if10.outValid !== 1'b1) begin
        nErr++; $display("FAIL rand_hold[%0d]: got %h/%b want %h/1", b, if10.cipherOut, if10.outValid, exp_c); end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] p1 = rnd128();
    logic [127:0] p2 = rnd128();
    logic [127:0] c1;
    bit acc;
    int lat;
    int bad = 0;
    mode = 1;
    offer(p1, acc);
    wait_out(lat);
    c1 = if10.cipherOut;
    nCmp++; if (c1 !== model(p1, NR10)) begin nErr++; $display("FAIL bp_cipher1: got %h want %h", c1, model(p1, NR10)); end
    if10.plainIn = p2;
    if10.inValid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      if (if10.cipherOut !== c1 || if10.inReady !== 1'b0 || if10.outValid !== 1'b1) bad++;
      @(negedge clk);
    end
    nCmp++; if (bad !== 0) begin nErr++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
    if10.outReady = 1'b1;
    #1;
    nCmp++; if (if10.inReady !== 1'b0) begin nErr++; $display("FAIL bp_inReady_release: got %b want 0", if10.inReady); end
    @(negedge clk);
    if10.outReady = 1'b0;
    #1;
    nCmp++; if (if10.busy !== 1'b0 || if10.outValid !== 1'b0 || if10.inReady !== 1'b1) begin
      nErr++; $display("FAIL bp_idle: got busy %b outValid %b inReady %b want 0 0 1", if10.busy, if10.outValid, if10.inReady); end
    @(negedge clk);
    if10.inValid = 1'b0;
    nCmp++; if (if10.busy !== 1'b1) begin nErr++; $display("FAIL bp_accept_next: got busy %b want 1", if10.busy); end
    wait_out(lat);
    nCmp++; if (lat !== NR10 + 1 || if10.cipherOut !== model(p2, NR10)) begin
      nErr++; $display("FAIL bp_cipher2: got %h lat %0d want %h lat %0d", if10.cipherOut, lat, model(p2, NR10), NR10 + 1); end
    release_out();
  endtask

  task automatic test_keyready();
    logic [127:0] p = rnd128();
    int lat;
    int bad = 0;
    mode = 1;
    if10.keyReady = 1'b0;
    if10.plainIn = p;
    if10.inValid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      if (if10.inReady !== 1'b0 || if10.busy !== 1'b0) bad++;
      @(negedge clk);
    end
    nCmp++; if (bad !== 0) begin nErr++; $display("FAIL key_gate: got %0d bad cycles want 0", bad); end
    if10.keyReady = 1'b1;
    #1;
    nCmp++; if (if10.inReady !== 1'b1) begin nErr++; $display("FAIL key_inReady: got %b want 1", if10.inReady); end
    @(negedge clk);
    if10.inValid = 1'b0;
    nCmp++; if (if10.busy !== 1'b1) begin nErr++; $display("FAIL key_accept: got busy %b want 1", if10.busy); end
    if10.keyReady = 1'b0;
    wait_out(lat);
    nCmp++; if (lat !== NR10 + 1 || if10.cipherOut !== model(p, NR10)) begin
      nErr++; $display("FAIL key_drop_cipher: got %h lat %0d want %h lat %0d", if10.cipherOut, lat, model(p, NR10), NR10 + 1); end
    release_out();
    if10.keyReady = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [127:0] p = rnd128();
    bit acc;
    int lat;
    int n = 0;
    int seen = 0;
    mode = 1;
    offer(p, acc);
    while (if10.rkIdx != 4'd5 && n < 20) begin @(negedge clk); n++; end
    nCmp++; if (if10.rkIdx !== 4'd5) begin nErr++; $display("FAIL rmid_reach5: got %0d want 5", if10.rkIdx); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nCmp++; if (if10.busy !== 1'b0 || if10.cipherOut !== 128'd0 || if10.rkIdx !== 4'd0 || if10.outValid !== 1'b0) begin
      nErr++; $display("FAIL rmid_state: got busy %b cipher %h rkIdx %0d outValid %b want 0 0 0 0",
                       if10.busy, if10.cipherOut, if10.rkIdx, if10.outValid); end
    for (int k = 0; k < 15; k++) begin if (if10.outValid) seen++; @(negedge clk); end
    nCmp++; if (seen !== 0) begin nErr++; $display("FAIL rmid_no_out: got %0d outValid cycles want 0", seen); end
    offer(p, acc);
    wait_out(lat);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nCmp++; if (if10.outValid !== 1'b0 || if10.busy !== 1'b0) begin
      nErr++; $display("FAIL rdone_abandon: got outValid %b busy %b want 0 0", if10.outValid, if10.busy); end
    p = rnd128();
    offer(p, acc);
    wait_out(lat);
    nCmp++; if (lat !== NR10 + 1 || if10.cipherOut !== model(p, NR10)) begin
      nErr++; $display("FAIL rmid_next: got %h lat %0d want %h lat %0d", if10.cipherOut, lat, model(p, NR10), NR10 + 1); end
    release_out();
  endtask

  task automatic test_nr14();
    logic [127:0] p = 128'h0123456789abcdef0123456789abcdef;
    int lat = 1;
    int bad = 0;
    int lastCnt = 0;
    mode = 0;
    if14.plainIn = p;
    if14.inValid = 1'b1;
    #1;
    nCmp++; if (if14.inReady !== 1'b1) begin nErr++; $display("FAIL nr14_inReady: got %b want 1", if14.inReady); end
    @(negedge clk);
    if14.inValid = 1'b0;
    while (!if14.outValid && lat < 40) begin
      if (if14.rfLast !== (if14.rkIdx == 4'd14)) bad++;
      if (if14.rfLast) lastCnt++;
      @(negedge clk);
      lat++;
    end
    nCmp++; if (bad !== 0 || lastCnt !== 1) begin nErr++; $display("FAIL nr14_rfLast: got %0d bad, %0d last want 0, 1", bad, lastCnt); end
    nCmp++; if (lat !== NR14 + 1) begin nErr++; $display("FAIL nr14_latency: got %0d want %0d", lat, NR14 + 1); end
    // the XOR of key indices 0..14 is 4'hf
    nCmp++; if (if14.cipherOut !== model(p, NR14)) begin nErr++; $display("FAIL nr14_cipher: got %h want %h", if14.cipherOut, model(p, NR14)); end
    nCmp++; if (if14.rfLast !== 1'b0) begin nErr++; $display("FAIL nr14_rfLast_done: got %b want 0", if14.rfLast); end
    if14.outReady = 1'b1;
    @(negedge clk);
    if14.outReady = 1'b0;
    nCmp++; if (if14.busy !== 1'b0) begin nErr++; $display("FAIL nr14_idle: got busy %b want 0", if14.busy); end
  endtask

  initial begin
    if10.inValid = 1'b0; if10.plainIn = '0; if10.keyReady = 1'b1; if10.outReady = 1'b0;
    if14.inValid = 1'b0; if14.plainIn = '0; if14.keyReady = 1'b1; if14.outReady = 1'b0;
    for (int i = 0; i < 16; i++) begin rkTab[i] = '0; aesRk[i] = '0; end
    test_reset();
    test_stub();
    test_fips();
    test_random();
    test_backpressure();
    test_keyready();
    test_reset_mid();
    test_nr14();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
